lab1_button_debounce: RTL and testbench
=======================================

# lab1_button_debounce

Per-channel synchronizer and debouncer for raw push-button/switch inputs on the Lab1 LED system board. It sits directly upstream of the 4-bit input PIO. It takes asynchronous, bouncy pad signals and produces clean, glitch-free levels that drive the PIO `in_port`. It also produces one-cycle rise/fall strobes for any logic that wants edges instead of levels.

## Interface
- `WIDTH`, default 4: number of independent input channels; must match the PIO `in_port` width.
- `DEBOUNCE_CYCLES`, default 50000: consecutive stable synchronized cycles required before a level change is accepted (1 ms at 50 MHz); legal range 2..2^20.
- `ACTIVE_LOW`, default 1: when 1, each channel is inverted after synchronization, so a pressed (low) button reads 1.
- `clk`  in  1: system clock; the only clock.
- `reset_n`  in  1: reset, synchronous, active-low; sampled on the rising edge of `clk`.
- `raw_in`  in  WIDTH: asynchronous pad inputs.
- `clean_out`  out  WIDTH: debounced level per channel; drives PIO `in_port`.
- `rise_pulse`  out  WIDTH: one-cycle strobe when `clean_out[i]` goes 0→1.
- `fall_pulse`  out  WIDTH: one-cycle strobe when `clean_out[i]` goes 1→0.

## Operation
- Per channel, a 2-flop synchronizer feeds an optional inverter. Its output is the sample `s[i]`.
- Synchronizer flops reset to the idle pad level: 1 if `ACTIVE_LOW`=1, else 0. As a result, `s[i]`=0 immediately after reset and no spurious edge is generated.
- Per channel, a counter of width clog2(`DEBOUNCE_CYCLES`) and a state bit `clean_out[i]`.
- The state bit forms a two-state machine per channel: STABLE_0 / STABLE_1. The counter tracks pending-change progress.
- Each cycle, when `s[i]` == `clean_out[i]`: the counter is cleared to 0 and no change occurs.
- Each cycle, when `s[i]` != `clean_out[i]` and the counter is below `DEBOUNCE_CYCLES`-1: the counter increments by 1.
- Each cycle, when `s[i]` != `clean_out[i]` and the counter equals `DEBOUNCE_CYCLES`-1: `clean_out[i]` <= `s[i]`, the counter <= 0, and exactly one of `rise_pulse[i]`/`fall_pulse[i]` is asserted for the next cycle only.
- Any disagreement shorter than `DEBOUNCE_CYCLES` cycles is discarded entirely, because the counter restarts from 0 on every return to agreement. There is no hysteresis beyond this.
- The counter never exceeds `DEBOUNCE_CYCLES`-1 and never wraps.
- Channels are fully independent. Simultaneous changes on several channels are handled in parallel, and each channel gets its own pulse on the same cycle if their timing coincides.
- `rise_pulse` and `fall_pulse` are registered and are never both high on one channel.

## Timing
- Reset values: `clean_out`=0, `rise_pulse`=0, `fall_pulse`=0, all counters=0, synchronizer flops=idle level.
- Reset takes effect on the first rising edge with `reset_n`=0 and holds while low. Reset mid-count abandons the pending change with no pulse.
- On the first edge with `reset_n`=1, normal operation resumes from the reset state.
- Edge numbering: call edge 1 the first rising edge at which `raw_in[i]` presents a new, held level.
- Latency: `s[i]` reflects the new level after edge 2. `clean_out[i]` changes on edge `DEBOUNCE_CYCLES`+2, and the matching pulse is high from edge `DEBOUNCE_CYCLES`+2 until edge `DEBOUNCE_CYCLES`+3.
- The PIO sees the new level in `in_port` in the same cycle that `clean_out` changes. The PIO adds its own read/irq latency.
- Minimum accepted pulse width on `raw_in`: `DEBOUNCE_CYCLES` cycles (plus synchronizer phase uncertainty of ±1 cycle for truly asynchronous inputs).
- Maximum toggle rate of `clean_out[i]`: once per `DEBOUNCE_CYCLES` cycles.

## Test plan
- Reset/idle: set `ACTIVE_LOW`=1, `raw_in`=4'b1111, and hold `reset_n` low for 3 edges, then release. Required: `clean_out`=0, with no pulses for 20 cycles.
- Clean press: set `DEBOUNCE_CYCLES`=4, and drive `raw_in[0]` 1→0 before edge 1, holding it. Required: `clean_out[0]`=1 after edge 6, and `rise_pulse[0]`=1 for exactly the cycle after edge 6.
- Bounce rejection: with `DEBOUNCE_CYCLES`=4, toggle `raw_in[1]` low 3 cycles, high 1, low 2, high, repeating for 40 cycles. Required: `clean_out[1]` stays 0 and no pulse occurs. Then hold low; required: `clean_out[1]`=1 at edge 6 counted from the final transition.
- Release and independence: with channels 0 and 2 pressed, release both on the same cycle. Required: `fall_pulse`=4'b0101 for one cycle at `DEBOUNCE_CYCLES`+2, and channels 1 and 3 remain unaffected.
- Reset mid-count: start a press, then assert `reset_n` low at edge 4 of a `DEBOUNCE_CYCLES`=8 count. Required: no pulse, `clean_out`=0. After release with the button still held, required: `clean_out` goes to 1 a full `DEBOUNCE_CYCLES`+2 edges later.
- Saturation boundary: use `DEBOUNCE_CYCLES`=2 and hold `raw_in[3]` changed for exactly 1 synchronized cycle (rejected), then for exactly 2 (accepted). Required: exactly one `rise_pulse[3]`.

Source files
------------

// File: rtl/lab1_button_debounce.sv
// Per-channel 2-flop synchronizer and counter-based debouncer for raw button pads.
// Produces clean levels for the PIO in_port plus one-cycle rise/fall strobes.
`timescale 1ns/1ps

module lab1_button_debounce #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] clean_out,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse
);

    localparam int               CNT_W      = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [WIDTH-1:0] IDLE_LEVEL = {WIDTH{ACTIVE_LOW}};

    typedef enum logic {
        STABLE_0 = 1'b0,
        STABLE_1 = 1'b1
    } state_e;

    logic [WIDTH-1:0] sync1_q, sync2_q;
    logic [WIDTH-1:0] sample;
    state_e           state_q [WIDTH];
    state_e           state_d [WIDTH];
    logic [CNT_W-1:0] cnt_q   [WIDTH];
    logic [CNT_W-1:0] cnt_d   [WIDTH];
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;

    // Synchronizer idles at the released pad level so sample starts at 0 with no edge.
    assign sample = ACTIVE_LOW ? ~sync2_q : sync2_q;

    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            // NOTE: every output of this block gets a default first, so no latch is inferred.
            state_d[i] = state_q[i];
            cnt_d[i]   = '0;
            rise_d[i]  = 1'b0;
            fall_d[i]  = 1'b0;
            if (sample[i] != (state_q[i] == STABLE_1)) begin
                if (cnt_q[i] == CNT_LAST) begin
                    state_d[i] = sample[i] ? STABLE_1 : STABLE_0;
                    rise_d[i]  = sample[i];
                    fall_d[i]  = ~sample[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous; it is only seen on a rising clock edge.
        if (!reset_n) begin
            sync1_q <= IDLE_LEVEL;
            sync2_q <= IDLE_LEVEL;
            rise_q  <= '0;
            fall_q  <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                state_q[i] <= STABLE_0;
                cnt_q[i]   <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            sync1_q <= raw_in;
            sync2_q <= sync1_q;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            for (int i = 0; i < WIDTH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            clean_out[i] = (state_q[i] == STABLE_1);
        end
    end

    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;

endmodule

// File: tb/tb_lab1_button_debounce.sv
// Directed bench for lab1_button_debounce: four instances cover DEBOUNCE_CYCLES 4/8/2
// and ACTIVE_LOW=0; outputs are sampled 1 ns after each rising edge.
`timescale 1ns/1ps

module tb_lab1_button_debounce;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, rst_b_n;
    logic [3:0] raw_a, raw_b, raw_c, raw_d;
    logic [3:0] clean_a, rise_a, fall_a;
    logic [3:0] clean_b, rise_b, fall_b;
    logic [3:0] clean_c, rise_c, fall_c;
    logic [3:0] clean_d, rise_d, fall_d;

    lab1_button_debounce #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .ACTIVE_LOW(1'b1)) dut_a (
        .clk(clk), .reset_n(rst_n), .raw_in(raw_a),
        .clean_out(clean_a), .rise_pulse(rise_a), .fall_pulse(fall_a));

    lab1_button_debounce #(.WIDTH(4), .DEBOUNCE_CYCLES(8), .ACTIVE_LOW(1'b1)) dut_b (
        .clk(clk), .reset_n(rst_b_n), .raw_in(raw_b),
        .clean_out(clean_b), .rise_pulse(rise_b), .fall_pulse(fall_b));

    lab1_button_debounce #(.WIDTH(4), .DEBOUNCE_CYCLES(2), .ACTIVE_LOW(1'b1)) dut_c (
        .clk(clk), .reset_n(rst_n), .raw_in(raw_c),
        .clean_out(clean_c), .rise_pulse(rise_c), .fall_pulse(fall_c));

    lab1_button_debounce #(.WIDTH(4), .DEBOUNCE_CYCLES(3), .ACTIVE_LOW(1'b0)) dut_d (
        .clk(clk), .reset_n(rst_n), .raw_in(raw_d),
        .clean_out(clean_d), .rise_pulse(rise_d), .fall_pulse(fall_d));

    typedef struct {
        logic [3:0] raw;
        logic [3:0] clean;
        logic [3:0] rise;
        logic [3:0] fall;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic add_vec(input logic [3:0] raw, input logic [3:0] clean,
                           input logic [3:0] rise, input logic [3:0] fall, input int reps);
        vec_t v;
        v.raw   = raw;
        v.clean = clean;
        v.rise  = rise;
        v.fall  = fall;
        repeat (reps) vecs.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compares {clean, rise, fall} of one instance.
    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got clean/rise/fall=%h, expected %h", name, act, exp);
        end
    endtask

    initial begin
        logic [0:6]  bounce_low;
        logic [13:0] c_low;
        logic [11:0] c_exp [14];
        int          rise_cnt;

        // Main table for instance A (DEBOUNCE_CYCLES=4): press ch0, press ch2, release both.
        add_vec(4'b1110, 4'b0000, 4'b0000, 4'b0000, 5);
        add_vec(4'b1110, 4'b0001, 4'b0001, 4'b0000, 1);
        add_vec(4'b1110, 4'b0001, 4'b0000, 4'b0000, 1);
        add_vec(4'b1010, 4'b0001, 4'b0000, 4'b0000, 5);
        add_vec(4'b1010, 4'b0101, 4'b0100, 4'b0000, 1);
        add_vec(4'b1010, 4'b0101, 4'b0000, 4'b0000, 1);
        add_vec(4'b1111, 4'b0101, 4'b0000, 4'b0000, 5);
        add_vec(4'b1111, 4'b0000, 4'b0000, 4'b0101, 1);
        add_vec(4'b1111, 4'b0000, 4'b0000, 4'b0000, 1);

        rst_n   = 1'b0;
        rst_b_n = 1'b0;
        raw_a   = 4'b1111;
        raw_b   = 4'b1111;
        raw_c   = 4'b1111;
        raw_d   = 4'b0000;
        repeat (3) tick();
        check("reset_a", {clean_a, rise_a, fall_a}, 12'h000);
        check("reset_b", {clean_b, rise_b, fall_b}, 12'h000);
        check("reset_c", {clean_c, rise_c, fall_c}, 12'h000);
        check("reset_d", {clean_d, rise_d, fall_d}, 12'h000);

        rst_n   = 1'b1;
        rst_b_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check($sformatf("idle_a_%0d", i), {clean_a, rise_a, fall_a}, 12'h000);
        end

        for (int i = 0; i < vecs.size(); i++) begin
            raw_a = vecs[i].raw;
            tick();
            check($sformatf("vec_%0d", i), {clean_a, rise_a, fall_a},
                  {vecs[i].clean, vecs[i].rise, vecs[i].fall});
        end

        // Bounce on ch1: low runs of at most 3 cycles must never be accepted.
        bounce_low = 7'b1110110;
        for (int i = 0; i < 40; i++) begin
            raw_a[1] = ~bounce_low[i % 7];
            tick();
            check($sformatf("bounce_%0d", i), {clean_a, rise_a, fall_a}, 12'h000);
        end
        raw_a[1] = 1'b1;
        repeat (2) begin
            tick();
            check("bounce_gap", {clean_a, rise_a, fall_a}, 12'h000);
        end
        raw_a[1] = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            check($sformatf("bounce_hold_e%0d", i), {clean_a, rise_a, fall_a}, 12'h000);
        end
        tick();
        check("bounce_hold_e6", {clean_a, rise_a, fall_a}, {4'b0010, 4'b0010, 4'b0000});
        tick();
        check("bounce_hold_e7", {clean_a, rise_a, fall_a}, {4'b0010, 4'b0000, 4'b0000});

        // Instance B (DEBOUNCE_CYCLES=8): reset lands at edge 4 of a pending press.
        raw_b = 4'b1110;
        for (int i = 1; i <= 3; i++) begin
            tick();
            check($sformatf("midrst_pre_e%0d", i), {clean_b, rise_b, fall_b}, 12'h000);
        end
        rst_b_n = 1'b0;
        repeat (2) begin
            tick();
            check("midrst_in_reset", {clean_b, rise_b, fall_b}, 12'h000);
        end
        rst_b_n = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            tick();
            check($sformatf("midrst_post_e%0d", i), {clean_b, rise_b, fall_b}, 12'h000);
        end
        tick();
        check("midrst_post_e10", {clean_b, rise_b, fall_b}, {4'b0001, 4'b0001, 4'b0000});
        tick();
        check("midrst_post_e11", {clean_b, rise_b, fall_b}, {4'b0001, 4'b0000, 4'b0000});

        // Instance C (DEBOUNCE_CYCLES=2): 1-cycle press rejected, 2-cycle press accepted.
        c_low = 14'b00_0000_1100_0001;
        for (int i = 0; i < 14; i++) c_exp[i] = 12'h000;
        c_exp[9]  = {4'b1000, 4'b1000, 4'b0000};
        c_exp[10] = {4'b1000, 4'b0000, 4'b0000};
        c_exp[11] = {4'b0000, 4'b0000, 4'b1000};
        rise_cnt  = 0;
        for (int i = 0; i < 14; i++) begin
            raw_c = {~c_low[i], 3'b111};
            tick();
            if (rise_c[3]) rise_cnt++;
            check($sformatf("sat_c%0d", i), {clean_c, rise_c, fall_c}, c_exp[i]);
        end
        check("sat_rise_count", 12'(rise_cnt), 12'd1);

        // Instance D (ACTIVE_LOW=0, DEBOUNCE_CYCLES=3): high pad reads as pressed.
        raw_d = 4'b0001;
        for (int i = 1; i <= 4; i++) begin
            tick();
            check($sformatf("al0_e%0d", i), {clean_d, rise_d, fall_d}, 12'h000);
        end
        tick();
        check("al0_e5", {clean_d, rise_d, fall_d}, {4'b0001, 4'b0001, 4'b0000});
        tick();
        check("al0_e6", {clean_d, rise_d, fall_d}, {4'b0001, 4'b0000, 4'b0000});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
